// File: rtl/cmd_frame_parser.sv
// Parses AA 55 CMD LEN_H LEN_L payload CHK frames. Outputs are registered one cycle after the byte; there is no backpressure.
// Define PARSER_TIMEOUT_EN to abort frames that go idle for TIMEOUT_CYCLES cycles.
module cmd_frame_parser #(
    parameter int MAX_LEN        = 256,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  usb_data_in,
    input  logic        usb_data_valid_in,
    output logic        cmd_start,
    output logic [7:0]  cmd_type,
    output logic [15:0] cmd_length,
    output logic [7:0]  cmd_data,
    output logic        cmd_data_valid,
    output logic [15:0] cmd_data_index,
    output logic        cmd_done,
    output logic        parse_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SOF2,
        S_CMD,
        S_LEN_H,
        S_LEN_L,
        S_DATA,
        S_CHK
    } state_t;

    localparam logic [16:0] MAX_LEN_W = 17'(MAX_LEN);

    state_t      state;
    logic [7:0]  sum;
    logic [7:0]  len_hi;
    logic [15:0] byte_cnt;
    logic [16:0] len_rx;

`ifdef PARSER_TIMEOUT_EN
    localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] idle_cnt;
`endif

    assign len_rx = {1'b0, len_hi, usb_data_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            sum            <= 8'd0;
            len_hi         <= 8'd0;
            byte_cnt       <= 16'd0;
            cmd_start      <= 1'b0;
            cmd_type       <= 8'd0;
            cmd_length     <= 16'd0;
            cmd_data       <= 8'd0;
            cmd_data_valid <= 1'b0;
            cmd_data_index <= 16'd0;
            cmd_done       <= 1'b0;
            parse_error    <= 1'b0;
`ifdef PARSER_TIMEOUT_EN
            idle_cnt       <= 16'd0;
`endif
        end else begin
            cmd_start      <= 1'b0;
            cmd_data_valid <= 1'b0;
            cmd_done       <= 1'b0;
            parse_error    <= 1'b0;

            if (usb_data_valid_in) begin
`ifdef PARSER_TIMEOUT_EN
                idle_cnt <= 16'd0;
`endif
                unique case (state)
                    S_IDLE: begin
                        if (usb_data_in == 8'hAA) state <= S_SOF2;
                    end
                    S_SOF2: begin
                        if (usb_data_in == 8'h55)      state <= S_CMD;
                        else if (usb_data_in != 8'hAA) state <= S_IDLE;
                    end
                    S_CMD: begin
                        sum   <= usb_data_in;
                        state <= S_LEN_H;
                    end
                    S_LEN_H: begin
                        len_hi <= usb_data_in;
                        sum    <= sum + usb_data_in;
                        state  <= S_LEN_L;
                    end
                    S_LEN_L: begin
                        sum <= sum + usb_data_in;
                        if (len_rx > MAX_LEN_W) begin
                            parse_error <= 1'b1;
                            state       <= S_IDLE;
                        end else begin
                            // The CMD byte is already folded into sum, so it is the only copy of it.
                            cmd_start  <= 1'b1;
                            cmd_type   <= sum - len_hi;
                            cmd_length <= len_rx[15:0];
                            byte_cnt   <= 16'd0;
                            state      <= (len_rx == 17'd0) ? S_CHK : S_DATA;
                        end
                    end
                    S_DATA: begin
                        cmd_data       <= usb_data_in;
                        cmd_data_valid <= 1'b1;
                        cmd_data_index <= byte_cnt;
                        sum            <= sum + usb_data_in;
                        if (byte_cnt == cmd_length - 16'd1) state <= S_CHK;
                        else                                 byte_cnt <= byte_cnt + 16'd1;
                    end
                    S_CHK: begin
                        if (usb_data_in == sum) cmd_done    <= 1'b1;
                        else                    parse_error <= 1'b1;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
`ifdef PARSER_TIMEOUT_EN
            else if (state != S_IDLE) begin
                if (idle_cnt == IDLE_LAST) begin
                    parse_error <= 1'b1;
                    state       <= S_IDLE;
                    idle_cnt    <= 16'd0;
                end else begin
                    idle_cnt <= idle_cnt + 16'd1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_cmd_frame_parser.sv
// Scoreboard bench for cmd_frame_parser: expected events are queued as bytes are driven and matched on output.
module tb_cmd_frame_parser;

    localparam int MAX_LEN = 256;
    localparam int TO      = 100;

    localparam int K_NONE  = 0;
    localparam int K_START = 1;
    localparam int K_DATA  = 2;
    localparam int K_DONE  = 3;
    localparam int K_ERR   = 4;

    typedef struct {
        int          kind;
        logic [15:0] a;
        logic [15:0] b;
        int          cyc;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  usb_data_in;
    logic        usb_data_valid_in;
    logic        cmd_start;
    logic [7:0]  cmd_type;
    logic [15:0] cmd_length;
    logic [7:0]  cmd_data;
    logic        cmd_data_valid;
    logic [15:0] cmd_data_index;
    logic        cmd_done;
    logic        parse_error;

    cmd_frame_parser #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYCLES(TO)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .usb_data_in       (usb_data_in),
        .usb_data_valid_in (usb_data_valid_in),
        .cmd_start         (cmd_start),
        .cmd_type          (cmd_type),
        .cmd_length        (cmd_length),
        .cmd_data          (cmd_data),
        .cmd_data_valid    (cmd_data_valid),
        .cmd_data_index    (cmd_data_index),
        .cmd_done          (cmd_done),
        .parse_error       (parse_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_checks = 0;
    int   n_errors = 0;
    ev_t  exp_q[$];
    logic [7:0] pl[$];
    bit   gap_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output monitor: at most one pulse per cycle, matched in order and by cycle.
    int          mon_n;
    int          mon_kind;
    logic [15:0] mon_a;
    logic [15:0] mon_b;
    ev_t         mon_e;
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            mon_n = 0;
            if (cmd_start)      mon_n++;
            if (cmd_data_valid) mon_n++;
            if (cmd_done)       mon_n++;
            if (parse_error)    mon_n++;
            if (mon_n > 1) begin
                check("one_pulse", mon_n, 1);
            end else if (mon_n == 1) begin
                mon_a = 16'd0;
                mon_b = 16'd0;
                if (cmd_start) begin
                    mon_kind = K_START; mon_a = {8'd0, cmd_type}; mon_b = cmd_length;
                end else if (cmd_data_valid) begin
                    mon_kind = K_DATA;  mon_a = {8'd0, cmd_data}; mon_b = cmd_data_index;
                end else if (cmd_done) begin
                    mon_kind = K_DONE;
                end else begin
                    mon_kind = K_ERR;
                end
                if (exp_q.size() == 0) begin
                    check("unexpected_event", mon_kind, K_NONE);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("event_kind",  mon_kind, mon_e.kind);
                    check("event_cycle", cyc,      mon_e.cyc);
                    check("event_a",     mon_a,    mon_e.a);
                    check("event_b",     mon_b,    mon_e.b);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            usb_data_valid_in = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int kind, input logic [15:0] a, input logic [15:0] bb);
        ev_t e;
        if (gap_en) idle($urandom_range(0, 2));
        @(negedge clk);
        usb_data_in       = b;
        usb_data_valid_in = 1'b1;
        if (kind != K_NONE) begin
            e.kind = kind;
            e.a    = a;
            e.b    = bb;
            e.cyc  = cyc + 1;
            exp_q.push_back(e);
        end
    endtask

    // Frame model: payload comes from pl; delta != 0 corrupts the checksum.
    task automatic send_frame(input logic [7:0] cmd, input int len, input logic [7:0] delta);
        logic [7:0]  s;
        logic [15:0] l16;
        l16 = 16'(len);
        send_byte(8'hAA, K_NONE, 16'd0, 16'd0);
        send_byte(8'h55, K_NONE, 16'd0, 16'd0);
        send_byte(cmd,   K_NONE, 16'd0, 16'd0);
        s = cmd;
        send_byte(l16[15:8], K_NONE, 16'd0, 16'd0);
        s = s + l16[15:8];
        if (len > MAX_LEN) begin
            send_byte(l16[7:0], K_ERR, 16'd0, 16'd0);
            return;
        end
        send_byte(l16[7:0], K_START, {8'd0, cmd}, l16);
        s = s + l16[7:0];
        for (int i = 0; i < len; i++) begin
            send_byte(pl[i], K_DATA, {8'd0, pl[i]}, 16'(i));
            s = s + pl[i];
        end
        send_byte(8'(s + delta), (delta == 8'd0) ? K_DONE : K_ERR, 16'd0, 16'd0);
    endtask

    task automatic fill_random(input int n);
        pl.delete();
        for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
    endtask

    task automatic drain(input string tag);
        idle(4);
        check(tag, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst_n             = 1'b0;
        usb_data_in       = 8'd0;
        usb_data_valid_in = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_type_len",  {8'd0, cmd_type, cmd_length}, 32'd0);
        check("rst_data_idx",  {8'd0, cmd_data, cmd_data_index}, 32'd0);
        check("rst_pulses",    {cmd_start, cmd_data_valid, cmd_done, parse_error}, 32'd0);
        rst_n = 1'b1;

        // Heartbeat
        pl.delete();
        send_frame(8'hFF, 0, 8'd0);
        drain("heartbeat_drained");

        // PWM frame, then bad checksum immediately followed by a heartbeat
        pl = '{8'h00, 8'h03, 8'hE8, 8'h01, 8'hF4};
        send_frame(8'hFE, 5, 8'd0);
        send_frame(8'hFE, 5, 8'd1);
        pl.delete();
        send_frame(8'hFF, 0, 8'd0);
        drain("pwm_drained");

        // Resync on repeated AA, then oversize length
        send_byte(8'h12, K_NONE, 16'd0, 16'd0);
        send_byte(8'hAA, K_NONE, 16'd0, 16'd0);
        send_frame(8'hFF, 0, 8'd0);
        send_frame(8'h08, 512, 8'd0);
        drain("resync_oversize_drained");

        // Length boundary: MAX_LEN accepted, MAX_LEN+1 rejected
        fill_random(MAX_LEN);
        send_frame(8'h5A, MAX_LEN, 8'd0);
        send_frame(8'h5B, MAX_LEN + 1, 8'd0);
        drain("maxlen_drained");

        // Random frames with idle gaps, some with corrupted checksums
        gap_en = 1'b1;
        for (int f = 0; f < 12; f++) begin
            fill_random($urandom_range(0, 10));
            send_frame(8'($urandom), pl.size(),
                       ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'd0);
        end
        gap_en = 1'b0;
        drain("random_drained");

        // Reset after three payload bytes of a five-byte frame
        send_byte(8'hAA, K_NONE, 16'd0, 16'd0);
        send_byte(8'h55, K_NONE, 16'd0, 16'd0);
        send_byte(8'h11, K_NONE, 16'd0, 16'd0);
        send_byte(8'h00, K_NONE, 16'd0, 16'd0);
        send_byte(8'h05, K_START, 16'h0011, 16'd5);
        send_byte(8'h21, K_DATA, 16'h0021, 16'd0);
        send_byte(8'h22, K_DATA, 16'h0022, 16'd1);
        send_byte(8'h23, K_DATA, 16'h0023, 16'd2);
        idle(1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_type_len", {8'd0, cmd_type, cmd_length}, 32'd0);
        check("midrst_data_idx", {8'd0, cmd_data, cmd_data_index}, 32'd0);
        check("midrst_pulses",   {cmd_start, cmd_data_valid, cmd_done, parse_error}, 32'd0);
        check("midrst_queue",    exp_q.size(), 0);
        idle(2);
        rst_n = 1'b1;
        pl = '{8'h31, 8'h32, 8'h33};
        send_frame(8'h21, 3, 8'd0);
        drain("after_reset_drained");

`ifdef PARSER_TIMEOUT_EN
        send_byte(8'hAA, K_NONE, 16'd0, 16'd0);
        send_byte(8'h55, K_NONE, 16'd0, 16'd0);
        send_byte(8'h0A, K_NONE, 16'd0, 16'd0);
        t = cyc;
        begin
            ev_t e;
            e.kind = K_ERR; e.a = 16'd0; e.b = 16'd0; e.cyc = t + 1 + TO;
            exp_q.push_back(e);
        end
        idle(TO + 10);
        drain("timeout_drained");
        pl.delete();
        send_frame(8'hFF, 0, 8'd0);
        drain("post_timeout_drained");
`else
        t = 0;
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
